tankb_scandoubler: RTL and testbench
====================================

TANKB_SCANDOUBLER -- requirements
Module: tankb_scandoubler

Interface
REQ-001 SHALL have parameter H_TOTAL, default 384, source pixels per input line (line-buffer depth used).
REQ-002 SHALL have parameter PIX_DIV, default 4, clk cycles per source pixel (even, >=2).
REQ-003 SHALL have parameter HS_W, default 46, output HSYNC width in output pixels.
REQ-004 SHALL have port clk, in, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port nRESET, in, 1: reset, synchronous, active-low.
REQ-006 SHALL have port pix_ce, in, 1: one-clk pulse per source pixel (6 MHz domain enable).
REQ-007 SHALL have ports pix_r, pix_g, pix_b, pix_i, in, 1 each: source colour bits (RED, GREEN, BLUE, RBG2).
REQ-008 SHALL have port pix_blank, in, 1: source blanking, high = black.
REQ-009 SHALL have ports nHSYNC_in and nVSYNC_in, in, 1 each: source syncs, active-low.
REQ-010 SHALL have ports VGA_R, VGA_G, VGA_B, out, 6 each: doubled-rate colour.
REQ-011 SHALL have ports VGA_HS and VGA_VS, out, 1 each: active-high syncs.
REQ-012 SHALL have port line_odd, out, 1: high during the second repeat of a source line.

Function
REQ-013 SHALL detect nHSYNC_in falling edge from a registered copy sampled each clk; this event = "line start".
REQ-014 SHALL, on each pix_ce, write {pix_b,pix_g,pix_r,pix_i} (forced 4'h0 when pix_blank=1) to the write bank at wr_x, then increment wr_x.
REQ-015 SHALL, at line start, clear wr_x to 0 and toggle the write bank; read bank is always the other bank.
REQ-016 SHALL saturate wr_x at H_TOTAL-1 (no wrap, further writes overwrite last entry).
REQ-017 SHALL generate out_ce once every PIX_DIV/2 clk cycles from a divider cleared at line start.
REQ-018 SHALL advance out_x 0..H_TOTAL-1 on out_ce; at wrap to 0, toggle line_odd; at line start force out_x=0, line_odd=0.
REQ-019 SHALL read the read bank at out_x; RAM latency 1 clk, output register 1 clk; colour, HS and line_odd share the same 2-clk pipeline.
REQ-020 SHALL assert VGA_HS for out_x in [0, HS_W).
REQ-021 SHALL update VGA_VS = ~nVSYNC_in only at output line boundaries (out_x=0 on out_ce or line start).
REQ-022 SHALL map each channel: bit=0 -> 6'h00; bit=1,i=0 -> 6'h2A; bit=1,i=1 -> 6'h3F.
REQ-023 SHALL hold colour outputs 0 until "locked", set after the second line start following reset.
REQ-024 SHALL treat a line start arriving before out_x wraps twice (short line) as resync: no out-of-range read, no extra HS pulse.

Reset
REQ-025 SHALL, with nRESET=0 at a clk edge, clear wr_x, out_x, divider, bank select, line_odd, locked, and drive VGA_R/G/B=0, VGA_HS=0, VGA_VS=0 on the next edge; line-buffer contents not cleared.
REQ-026 SHALL restart cleanly on reset mid-line: first output line begins at the next line start.

Configuration
REQ-027 SHALL, with TANKB_SCANLINES_EN defined, output during line_odd=1 each 6-bit channel shifted right by 1 (6'h3F->6'h1F, 6'h2A->6'h15).
REQ-028 SHALL, without TANKB_SCANLINES_EN, output both line repeats identically.

Structure
REQ-029 SHALL place H_TOTAL/HS_W defaults, pixel 4-bit encoding and colour-level constants (6'h2A, 6'h3F) in shared package tankb_video_pkg.
REQ-030 SHALL instantiate one sub-module tankb_linebuf: 2x512x4 simple dual-port RAM, one write port, one registered read port, bank select as address MSB.

Verification
REQ-031 Reset then three 384-pixel lines of constant colour r=1,i=0 -> from third output line pair VGA_R=6'h2A, VGA_G=VGA_B=0, two HS pulses of 46 out_ce per input line.
REQ-032 Ramp pixel index n mod 16 written line k -> line k+1 output shows the same sequence twice, line_odd 0 then 1, 2-clk latency from read address.
REQ-033 pix_blank=1 for pixels 0..63 -> output channels 0 for out_x 0..63 on both repeats.
REQ-034 Line start after only 200 pixels -> out_x forced to 0, line_odd=0, no HS glitch, wr_x restarts at 0.
REQ-035 nRESET low for 1 clk mid-line -> all outputs 0 next edge, colour stays 0 until second subsequent line start.
REQ-036 With TANKB_SCANLINES_EN, white i=1 input -> 6'h3F on line_odd=0, 6'h1F on line_odd=1; without macro 6'h3F both.

Source files
------------

// File: rtl/tankb_video_pkg.sv
// Shared video constants for the tank-B scan doubler: line-buffer geometry,
// 4-bit pixel encoding and the 6-bit colour levels.
package tankb_video_pkg;

   localparam int H_TOTAL_DEF = 384;
   localparam int HS_W_DEF    = 46;

   localparam int LB_AW    = 9;
   localparam int LB_DEPTH = 1 << LB_AW;

   // stored pixel, bit order {b,g,r,i}
   typedef struct packed {
      logic b;
      logic g;
      logic r;
      logic i;
   } pix_t;

   localparam pix_t PIX_BLACK = '0;

   localparam logic [5:0] LVL_OFF  = 6'h00;
   localparam logic [5:0] LVL_MID  = 6'h2A;
   localparam logic [5:0] LVL_FULL = 6'h3F;

   typedef enum logic [1:0] {
      SYNC_WAIT   = 2'd0,
      SYNC_ARMED  = 2'd1,
      SYNC_LOCKED = 2'd2
   } sync_e;

   function automatic logic [5:0] chan_level(input logic bit_on,
                                             input logic inten,
                                             input logic dim);
      logic [5:0] lvl;
      lvl = bit_on ? (inten ? LVL_FULL : LVL_MID) : LVL_OFF;
      return dim ? (lvl >> 1) : lvl;
   endfunction

endpackage

// File: rtl/tankb_linebuf.sv
// Two-bank line buffer: one write port, one registered read port,
// bank select used as the address MSB.
module tankb_linebuf
   import tankb_video_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic             wr_bank,
   input  logic [LB_AW-1:0] wr_addr,
   input  pix_t             wr_data,
   input  logic             rd_bank,
   input  logic [LB_AW-1:0] rd_addr,
   output pix_t             rd_data
);

   pix_t mem [2*LB_DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[{wr_bank, wr_addr}] <= wr_data;
      rd_data <= mem[{rd_bank, rd_addr}];
   end

endmodule

// File: rtl/tankb_scandoubler.sv
// Tank-B scan doubler: captures each source line and replays it twice at
// double pixel rate. Define TANKB_SCANLINES_EN to dim the second repeat.
//
// state       | meaning
// SYNC_WAIT   | no line start since reset; output timing idle, syncs low
// SYNC_ARMED  | one line start seen; output timing runs, colour held black
// SYNC_LOCKED | read bank holds a captured line; colour enabled
module tankb_scandoubler
   import tankb_video_pkg::*;
#(
   parameter int H_TOTAL = H_TOTAL_DEF,
   parameter int PIX_DIV = 4,
   parameter int HS_W    = HS_W_DEF
) (
   input  logic       clk,
   input  logic       nRESET,
   input  logic       pix_ce,
   input  logic       pix_r,
   input  logic       pix_g,
   input  logic       pix_b,
   input  logic       pix_i,
   input  logic       pix_blank,
   input  logic       nHSYNC_in,
   input  logic       nVSYNC_in,
   output logic [5:0] VGA_R,
   output logic [5:0] VGA_G,
   output logic [5:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       line_odd
);

   localparam logic [LB_AW-1:0] X_LAST   = LB_AW'(H_TOTAL - 1);
   localparam logic [LB_AW:0]   HS_LIM   = (LB_AW+1)'(HS_W);
   localparam logic [7:0]       DIV_LAST = 8'(PIX_DIV/2 - 1);

   logic             nhs_q;
   logic             line_start;
   sync_e            state;
   sync_e            state_nx;
   logic             active;
   logic             locked;

   logic [LB_AW-1:0] wr_x;
   logic             wr_bank;
   pix_t             wr_pix;
   logic             we;

   logic [7:0]       div;
   logic             out_ce;
   logic [LB_AW-1:0] out_x;
   logic             odd_q;

   pix_t             rd_pix;
   logic             hs_p1;
   logic             odd_p1;
   logic             lk_p1;
   logic             dim;

   always_ff @(posedge clk) begin
      nhs_q <= nHSYNC_in;
   end

   assign line_start = nhs_q & ~nHSYNC_in;

   always_ff @(posedge clk) begin
      if (!nRESET)
         state <= SYNC_WAIT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         SYNC_WAIT:  if (line_start) state_nx = SYNC_ARMED;
         SYNC_ARMED: if (line_start) state_nx = SYNC_LOCKED;
         default:    state_nx = state;
      endcase
   end

   assign active = (state != SYNC_WAIT);
   assign locked = (state == SYNC_LOCKED);

   // write side: saturating pixel index, bank flips at every line start
   always_comb begin
      wr_pix = pix_blank ? PIX_BLACK : pix_t'({pix_b, pix_g, pix_r, pix_i});
   end

   assign we = pix_ce & nRESET;

   always_ff @(posedge clk) begin
      if (!nRESET) begin
         wr_x    <= '0;
         wr_bank <= 1'b0;
      end else if (line_start) begin
         wr_x    <= '0;
         wr_bank <= ~wr_bank;
      end else if (pix_ce && (wr_x != X_LAST)) begin
         wr_x <= wr_x + 1'b1;
      end
   end

   // output timing: divider is a down-counter, out_ce on terminal count
   assign out_ce = active && (div == 8'd0);

   always_ff @(posedge clk) begin
      if (!nRESET) begin
         div    <= '0;
         out_x  <= '0;
         odd_q  <= 1'b0;
         VGA_VS <= 1'b0;
      end else if (line_start) begin
         div    <= DIV_LAST;
         out_x  <= '0;
         odd_q  <= 1'b0;
         VGA_VS <= ~nVSYNC_in;
      end else if (out_ce) begin
         div <= DIV_LAST;
         if (out_x == X_LAST) begin
            out_x  <= '0;
            odd_q  <= ~odd_q;
            VGA_VS <= ~nVSYNC_in;
         end else begin
            out_x <= out_x + 1'b1;
         end
      end else if (div != 8'd0) begin
         div <= div - 1'b1;
      end
   end

   tankb_linebuf u_linebuf (
      .clk     (clk),
      .we      (we),
      .wr_bank (wr_bank),
      .wr_addr (wr_x),
      .wr_data (wr_pix),
      .rd_bank (~wr_bank),
      .rd_addr (out_x),
      .rd_data (rd_pix)
   );

   // sideband delayed to line up with the RAM read latency
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         hs_p1  <= 1'b0;
         odd_p1 <= 1'b0;
         lk_p1  <= 1'b0;
      end else begin
         hs_p1  <= active && ({1'b0, out_x} < HS_LIM);
         odd_p1 <= odd_q;
         lk_p1  <= locked;
      end
   end

   always_comb begin
`ifdef TANKB_SCANLINES_EN
      dim = odd_p1;
`else
      dim = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!nRESET) begin
         VGA_R    <= '0;
         VGA_G    <= '0;
         VGA_B    <= '0;
         VGA_HS   <= 1'b0;
         line_odd <= 1'b0;
      end else begin
         VGA_R    <= lk_p1 ? chan_level(rd_pix.r, rd_pix.i, dim) : LVL_OFF;
         VGA_G    <= lk_p1 ? chan_level(rd_pix.g, rd_pix.i, dim) : LVL_OFF;
         VGA_B    <= lk_p1 ? chan_level(rd_pix.b, rd_pix.i, dim) : LVL_OFF;
         VGA_HS   <= hs_p1;
         line_odd <= odd_p1;
      end
   end

endmodule

// File: tb/tb_tankb_scandoubler.sv
// Randomised bench for tankb_scandoubler: a line-level reference model checked
// every cycle, plus fixed expectations at chosen points of a line sequence.
module tb_tankb_scandoubler;

   localparam int H_TOTAL = 384;
   localparam int PIX_DIV = 4;
   localparam int HS_W    = 46;
   localparam int HALF    = PIX_DIV / 2;

`ifdef TANKB_SCANLINES_EN
   localparam bit         SCAN      = 1'b1;
   localparam logic [5:0] WHITE_ODD = 6'h1F;
`else
   localparam bit         SCAN      = 1'b0;
   localparam logic [5:0] WHITE_ODD = 6'h3F;
`endif

   logic       clk = 1'b0;
   logic       nRESET = 1'b0;
   logic       pix_ce = 1'b0;
   logic       pix_r = 1'b0, pix_g = 1'b0, pix_b = 1'b0, pix_i = 1'b0;
   logic       pix_blank = 1'b0;
   logic       nHSYNC_in = 1'b1;
   logic       nVSYNC_in = 1'b1;
   logic [5:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, line_odd;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   bit hs_prev = 1'b0;

   always #5 clk = ~clk;

   tankb_scandoubler #(.H_TOTAL(H_TOTAL), .PIX_DIV(PIX_DIV), .HS_W(HS_W)) dut (
      .clk       (clk),
      .nRESET    (nRESET),
      .pix_ce    (pix_ce),
      .pix_r     (pix_r),
      .pix_g     (pix_g),
      .pix_b     (pix_b),
      .pix_i     (pix_i),
      .pix_blank (pix_blank),
      .nHSYNC_in (nHSYNC_in),
      .nVSYNC_in (nVSYNC_in),
      .VGA_R     (VGA_R),
      .VGA_G     (VGA_G),
      .VGA_B     (VGA_B),
      .VGA_HS    (VGA_HS),
      .VGA_VS    (VGA_VS),
      .line_odd  (line_odd)
   );

   // reference model: two stored lines, position derived from cycles since line start
   logic [3:0] mem [2][H_TOTAL];
   int  wx = 0, cyc = 0, nls = 0;
   bit  wbank = 0, prev_hs = 1, vs_m = 0;
   bit  s1_hs = 0, s1_odd = 0, s1_lk = 0;
   logic [3:0] s1_pix = 4'h0;
   logic [5:0] e_r = 0, e_g = 0, e_b = 0;
   bit  e_hs = 0, e_odd = 0;

   initial begin
      for (int b = 0; b < 2; b++)
         for (int x = 0; x < H_TOTAL; x++)
            mem[b][x] = 4'h0;
   end

   function automatic logic [5:0] lvl(input bit on, input bit inten, input bit dim);
      int v;
      v = on ? (inten ? 63 : 42) : 0;
      if (dim) v = v / 2;
      return 6'(v);
   endfunction

   always @(posedge clk) begin
      bit act_now, ls, odd_now, hs_now, lk_now;
      int ox;
      act_now = (nls >= 1);
      ox      = act_now ? (cyc / HALF) % H_TOTAL : 0;
      odd_now = act_now ? (((cyc / HALF) / H_TOTAL) % 2 == 1) : 1'b0;
      hs_now  = act_now && (ox < HS_W);
      lk_now  = (nls >= 2);
      if (!nRESET) begin
         e_r = 0; e_g = 0; e_b = 0; e_hs = 0; e_odd = 0;
         s1_hs = 0; s1_odd = 0; s1_lk = 0; s1_pix = 0;
         wx = 0; wbank = 0; cyc = 0; nls = 0; vs_m = 0;
         prev_hs = nHSYNC_in;
      end else begin
         e_r   = s1_lk ? lvl(s1_pix[1], s1_pix[0], SCAN && s1_odd) : 6'h00;
         e_g   = s1_lk ? lvl(s1_pix[2], s1_pix[0], SCAN && s1_odd) : 6'h00;
         e_b   = s1_lk ? lvl(s1_pix[3], s1_pix[0], SCAN && s1_odd) : 6'h00;
         e_hs  = s1_hs;
         e_odd = s1_odd;
         s1_pix = mem[!wbank][ox];
         s1_hs  = hs_now;
         s1_odd = odd_now;
         s1_lk  = lk_now;
         ls = prev_hs && !nHSYNC_in;
         prev_hs = nHSYNC_in;
         if (pix_ce)
            mem[wbank][wx] = pix_blank ? 4'h0 : {pix_b, pix_g, pix_r, pix_i};
         if (ls) begin
            wx = 0; wbank = !wbank;
         end else if (pix_ce && wx < H_TOTAL - 1) begin
            wx++;
         end
         if (ls) begin
            cyc = 0;
            if (nls < 2) nls++;
            vs_m = !nVSYNC_in;
         end else if (act_now) begin
            cyc++;
            if (cyc % (HALF * H_TOTAL) == 0) vs_m = !nVSYNC_in;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (VGA_R !== e_r || VGA_G !== e_g || VGA_B !== e_b ||
             VGA_HS !== e_hs || VGA_VS !== vs_m || line_odd !== e_odd) begin
            bad++;
            $display("FAIL model t=%0t got r=%h g=%h b=%h hs=%b vs=%b odd=%b want r=%h g=%h b=%h hs=%b vs=%b odd=%b",
                     $time, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, line_odd,
                     e_r, e_g, e_b, e_hs, vs_m, e_odd);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // sample at iteration c shows the state after edge c-1; out_x 5 appears at c=13
   task automatic lit_checks(input int lidx, input int c);
      case (lidx)
         0: if (c == 5) chk("vs_first_line", VGA_VS, 1);
         3: if (c == 400) begin
               chk("red_r", VGA_R, 6'h2A);
               chk("red_g", VGA_G, 0);
               chk("red_b", VGA_B, 0);
            end
         4: if (c == 13) begin
               chk("ramp5_g", VGA_G, 6'h3F);
               chk("ramp5_r", VGA_R, 0);
               chk("ramp5_odd", line_odd, 0);
            end else if (c == 781) begin
               chk("ramp5_g_rep", VGA_G, WHITE_ODD);
               chk("ramp5_odd_rep", line_odd, 1);
            end
         5: if (c == 13) begin
               chk("blank_r", VGA_R, 0);
               chk("blank_g", VGA_G, 0);
               chk("blank_b", VGA_B, 0);
            end else if (c == 781) begin
               chk("blank_rep_g", VGA_G, 0);
               chk("blank_rep_odd", line_odd, 1);
            end
         6: if (c == 13) begin
               chk("short_odd", line_odd, 0);
               chk("short_hs", VGA_HS, 1);
            end
         7: if (c == 13) chk("white_even", VGA_R, 6'h3F);
            else if (c == 781) chk("white_odd", VGA_R, WHITE_ODD);
         8: if (c == 501) begin
               chk("rst_r", VGA_R, 0);
               chk("rst_hs", VGA_HS, 0);
               chk("rst_vs", VGA_VS, 0);
               chk("rst_odd", line_odd, 0);
            end else if (c == 600) begin
               chk("rst_vs_hold", VGA_VS, 0);
            end
         9: if (c == 13) begin
               chk("unlocked_r", VGA_R, 0);
               chk("unlocked_hs", VGA_HS, 1);
            end
         10: if (c == 13) begin
               chk("relock_r", VGA_R, 6'h3F);
               chk("relock_b", VGA_B, 6'h3F);
            end
         default: ;
      endcase
   endtask

   task automatic run_line(input int lidx, input int npix, input int mode, input int rst_at);
      int nclk, hs_rise, hs_high, n;
      bit nvs, tog;
      logic [3:0] v;
      nclk = npix * PIX_DIV;
      nvs = (lidx < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      tog = ($urandom_range(0, 1) == 1);
      hs_rise = 0;
      hs_high = 0;
      for (int c = 0; c < nclk; c++) begin
         @(negedge clk);
         if (VGA_HS && !hs_prev) hs_rise++;
         if (VGA_HS) hs_high++;
         hs_prev = VGA_HS;
         lit_checks(lidx, c);
         nRESET    = (c == rst_at) ? 1'b0 : 1'b1;
         nHSYNC_in = (c < 32) ? 1'b0 : 1'b1;
         nVSYNC_in = (tog && c >= 700) ? !nvs : nvs;
         pix_ce    = (c % PIX_DIV == 2);
         v         = 4'($urandom);
         pix_blank = ($urandom_range(0, 7) == 0);
         if (pix_ce) begin
            n = (c - 2) / PIX_DIV;
            case (mode)
               1: begin v = 4'b0010; pix_blank = 1'b0; end
               2: begin v = 4'(n % 16); pix_blank = 1'b0; end
               3: begin v = 4'b1111; pix_blank = 1'b0; end
               4: pix_blank = (n < 64);
               default: ;
            endcase
         end
         {pix_b, pix_g, pix_r, pix_i} = v;
      end
      if (lidx == 3) begin
         chk("hs_pulses_l3", hs_rise, 2);
         chk("hs_width_l3", hs_high, 4 * HS_W);
      end
      if (lidx == 4) chk("hs_pulses_l4", hs_rise, 2);
      if (lidx == 6) chk("hs_pulses_after_short", hs_rise, 1);
   endtask

   // line table: pixels, mode (0 rand,1 red,2 ramp,3 white,4 blank 0..63), reset clk
   int tbl_pix  [12] = '{384, 384, 384, 384, 384, 200, 384, 400, 384, 384, 384, 384};
   int tbl_mode [12] = '{1,   1,   1,   2,   4,   0,   3,   0,   3,   3,   0,   0};
   int tbl_rst  [12] = '{-1,  -1,  -1,  -1,  -1,  -1,  -1,  -1,  500, -1,  -1,  -1};

   initial begin
      nRESET = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_r", VGA_R, 0);
      chk("reset_g", VGA_G, 0);
      chk("reset_b", VGA_B, 0);
      chk("reset_hs", VGA_HS, 0);
      chk("reset_vs", VGA_VS, 0);
      chk("reset_odd", line_odd, 0);
      nRESET = 1'b1;
      repeat (20) @(negedge clk);
      for (int l = 0; l < 12; l++)
         run_line(l, tbl_pix[l], tbl_mode[l], tbl_rst[l]);
      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
